// File: rtl/qracc_pkg.sv
// Shared types for the tiled bit-serial accumulator: FSM states, latched configuration
// and the count clamp used when sampling configuration.
package qracc_pkg;

  // Wide enough for any practical maxInputBits / maxTiles (up to 255).
  localparam int CFG_CNT_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PLANE,
    WAIT_ADC,
    TILE_DONE,
    OUT
  } seq_acc_tiled_state_t;

  typedef struct packed {
    logic [CFG_CNT_W-1:0] n_input_bits;
    logic                 unsigned_acts;
    logic [CFG_CNT_W-1:0] n_tiles;
    logic [4:0]           out_shift;
  } seq_acc_tiled_cfg_t;

  // Zero means one; anything above the maximum is pulled down to the maximum.
  function automatic logic [CFG_CNT_W-1:0] clamp_count(input int val, input int max_val);
    int r;
    r = val;
    if (r < 1) r = 1;
    if (r > max_val) r = max_val;
    return CFG_CNT_W'(r);
  endfunction

endpackage

// File: rtl/seq_acc_tiled_col.sv
// One output column: Horner shift-accumulate of ADC codes per tile, cross-tile total,
// then arithmetic shift and saturation into a registered result.
module col_shift_acc #(
  parameter int adcBits    = 4,
  parameter int accBits    = 20,
  parameter int outputBits = 8
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  clear_all_i,
  input  logic                  clear_partial_i,
  input  logic                  adc_update_i,
  input  logic                  negate_i,
  input  logic [adcBits-1:0]    adc_i,
  input  logic                  tile_add_i,
  input  logic                  out_load_i,
  input  logic [4:0]            shift_i,
  output logic [outputBits-1:0] result_o
);

  localparam int SAT_MAX = (1 << (outputBits - 1)) - 1;
  localparam int SAT_MIN = -(1 << (outputBits - 1));

  logic signed [accBits-1:0] partial_q, partial_d;
  logic signed [accBits-1:0] total_q, total_d;
  logic signed [accBits-1:0] adc_ext, sum, shifted;
  logic [outputBits-1:0]     result_q, result_d;

  always_comb begin
    adc_ext   = accBits'($signed(adc_i));
    sum       = total_q + partial_q;
    shifted   = sum >>> shift_i;
    partial_d = partial_q;
    total_d   = total_q;
    result_d  = result_q;
    if (clear_all_i || clear_partial_i) begin
      partial_d = '0;
    end else if (adc_update_i) begin
      // The MSB plane of a signed activation carries negative weight.
      partial_d = negate_i ? -adc_ext : (partial_q <<< 1) + adc_ext;
    end
    if (clear_all_i) begin
      total_d = '0;
    end else if (tile_add_i) begin
      total_d = sum;
    end
    if (out_load_i) begin
      if (shifted > accBits'(SAT_MAX)) begin
        result_d = outputBits'(SAT_MAX);
      end else if (shifted < accBits'(SAT_MIN)) begin
        result_d = outputBits'(SAT_MIN);
      end else begin
        result_d = shifted[outputBits-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      partial_q <= '0;
      total_q   <= '0;
      result_q  <= '0;
    end else begin
      if (adc_update_i && !negate_i) begin
        assert (partial_q[accBits-1] == partial_q[accBits-2]);
      end
      if (tile_add_i) begin
        assert (!((total_q[accBits-1] == partial_q[accBits-1]) &&
                  (sum[accBits-1] != total_q[accBits-1])));
      end
      partial_q <= partial_d;
      total_q   <= total_d;
      result_q  <= result_d;
    end
  end

  assign result_o = result_q;

endmodule

// File: rtl/seq_acc_tiled.sv
// Tiled bit-serial accumulator: slices activation vectors into MSB-first bit-planes,
// collects per-column ADC codes, accumulates across tiles and emits saturated sums.
module seq_acc_tiled
  import qracc_pkg::*;
#(
  parameter int inputElements  = 128,
  parameter int outputElements = 32,
  parameter int maxInputBits   = 8,
  parameter int adcBits        = 4,
  parameter int accBits        = 20,
  parameter int outputBits     = 8,
  parameter int maxTiles       = 16
) (
  input  logic                                   clk,
  input  logic                                   nrst,
  input  logic [$clog2(maxInputBits+1)-1:0]      cfg_n_input_bits_i,
  input  logic                                   cfg_unsigned_acts_i,
  input  logic [$clog2(maxTiles+1)-1:0]          cfg_n_tiles_i,
  input  logic [4:0]                             cfg_out_shift_i,
  input  logic [inputElements*maxInputBits-1:0]  mac_data_i,
  input  logic                                   mac_valid_i,
  output logic                                   mac_ready_o,
  output logic [inputElements-1:0]               plane_o,
  output logic                                   plane_valid_o,
  input  logic                                   plane_ready_i,
  input  logic [outputElements*adcBits-1:0]      adc_i,
  input  logic                                   adc_valid_i,
  output logic [outputElements*outputBits-1:0]   mac_data_o,
  output logic                                   valid_o,
  input  logic                                   ready_i,
  output logic                                   busy_o,
  output seq_acc_tiled_state_t                   dbg_state_o
);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready are both
  // high; valid never depends on ready, and valid/data stay stable until the transfer.

  seq_acc_tiled_state_t state_q, state_d;
  seq_acc_tiled_cfg_t   cfg_q, cfg_d, cfg_in;
  logic [inputElements*maxInputBits-1:0] vec_q, vec_d;
  logic [CFG_CNT_W-1:0] b_q, b_d, t_q, t_d;
  logic ready_en_q;
  logic in_hs;
  logic clear_all, clear_partial, adc_update, negate, tile_add, out_load;

  assign mac_ready_o   = ready_en_q && ((state_q == IDLE) || (state_q == LOAD));
  assign in_hs         = mac_valid_i && mac_ready_o;
  assign plane_valid_o = (state_q == PLANE);
  assign valid_o       = (state_q == OUT);
  assign busy_o        = (state_q != IDLE);
  assign dbg_state_o   = state_q;

  always_comb begin
    cfg_in = '{n_input_bits:  clamp_count(int'(cfg_n_input_bits_i), maxInputBits),
               unsigned_acts: cfg_unsigned_acts_i,
               n_tiles:       clamp_count(int'(cfg_n_tiles_i), maxTiles),
               out_shift:     cfg_out_shift_i};
  end

  always_comb begin
    state_d       = state_q;
    cfg_d         = cfg_q;
    vec_d         = vec_q;
    b_d           = b_q;
    t_d           = t_q;
    clear_all     = 1'b0;
    clear_partial = 1'b0;
    adc_update    = 1'b0;
    negate        = 1'b0;
    tile_add      = 1'b0;
    out_load      = 1'b0;
    case (state_q)
      IDLE: if (in_hs) begin
        cfg_d     = cfg_in;
        vec_d     = mac_data_i;
        b_d       = cfg_in.n_input_bits - CFG_CNT_W'(1);
        t_d       = '0;
        clear_all = 1'b1;
        state_d   = PLANE;
      end
      LOAD: if (in_hs) begin
        vec_d         = mac_data_i;
        b_d           = cfg_q.n_input_bits - CFG_CNT_W'(1);
        clear_partial = 1'b1;
        state_d       = PLANE;
      end
      PLANE: if (plane_ready_i) state_d = WAIT_ADC;
      WAIT_ADC: if (adc_valid_i) begin
        adc_update = 1'b1;
        negate     = (b_q == cfg_q.n_input_bits - CFG_CNT_W'(1)) && !cfg_q.unsigned_acts;
        if (b_q != '0) begin
          b_d     = b_q - CFG_CNT_W'(1);
          state_d = PLANE;
        end else begin
          state_d = TILE_DONE;
        end
      end
      TILE_DONE: begin
        tile_add = 1'b1;
        t_d      = t_q + CFG_CNT_W'(1);
        // The result register loads from total+partial on the way into OUT.
        if (t_q + CFG_CNT_W'(1) == cfg_q.n_tiles) begin
          out_load = 1'b1;
          state_d  = OUT;
        end else begin
          state_d = LOAD;
        end
      end
      OUT: if (ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    plane_o = '0;
    if (state_q == PLANE) begin
      for (int i = 0; i < inputElements; i++) begin
        plane_o[i] = vec_q[i*maxInputBits + int'(b_q)];
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= IDLE;
      cfg_q      <= '0;
      vec_q      <= '0;
      b_q        <= '0;
      t_q        <= '0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      vec_q      <= vec_d;
      b_q        <= b_d;
      t_q        <= t_d;
      ready_en_q <= 1'b1;
    end
  end

  for (genvar c = 0; c < outputElements; c++) begin : g_col
    col_shift_acc #(
      .adcBits    (adcBits),
      .accBits    (accBits),
      .outputBits (outputBits)
    ) u_col (
      .clk             (clk),
      .nrst            (nrst),
      .clear_all_i     (clear_all),
      .clear_partial_i (clear_partial),
      .adc_update_i    (adc_update),
      .negate_i        (negate),
      .adc_i           (adc_i[c*adcBits +: adcBits]),
      .tile_add_i      (tile_add),
      .out_load_i      (out_load),
      .shift_i         (cfg_q.out_shift),
      .result_o        (mac_data_o[c*outputBits +: outputBits])
    );
  end

endmodule

// File: tb/tb_seq_acc_tiled.sv
// Directed bench for seq_acc_tiled with 4 rows, 2 columns, 4-bit activations and ADC codes.
module tb_seq_acc_tiled;

  localparam int IE = 4, OE = 2, MIB = 4, AB = 4, ACCB = 20, OB = 8, MT = 16;

  logic            clk = 1'b0;
  logic            nrst;
  logic [2:0]      cfg_n;
  logic            cfg_u;
  logic [4:0]      cfg_t;
  logic [4:0]      cfg_sh;
  logic [IE*MIB-1:0] mac_data_i;
  logic            mac_valid_i, mac_ready_o;
  logic [IE-1:0]   plane_o;
  logic            plane_valid_o, plane_ready_i;
  logic [OE*AB-1:0] adc_i;
  logic            adc_valid_i;
  logic [OE*OB-1:0] mac_data_o;
  logic            valid_o, ready_i, busy_o;
  qracc_pkg::seq_acc_tiled_state_t dbg_state;

  int checks = 0;
  int passed = 0;
  int cyc_cnt = 0;

  seq_acc_tiled #(
    .inputElements(IE), .outputElements(OE), .maxInputBits(MIB), .adcBits(AB),
    .accBits(ACCB), .outputBits(OB), .maxTiles(MT)
  ) dut (
    .clk(clk), .nrst(nrst),
    .cfg_n_input_bits_i(cfg_n), .cfg_unsigned_acts_i(cfg_u),
    .cfg_n_tiles_i(cfg_t), .cfg_out_shift_i(cfg_sh),
    .mac_data_i(mac_data_i), .mac_valid_i(mac_valid_i), .mac_ready_o(mac_ready_o),
    .plane_o(plane_o), .plane_valid_o(plane_valid_o), .plane_ready_i(plane_ready_i),
    .adc_i(adc_i), .adc_valid_i(adc_valid_i),
    .mac_data_o(mac_data_o), .valid_o(valid_o), .ready_i(ready_i),
    .busy_o(busy_o), .dbg_state_o(dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int n, input bit u, input int t, input int sh);
    cfg_n  = 3'(n);
    cfg_u  = u;
    cfg_t  = 5'(t);
    cfg_sh = 5'(sh);
  endtask

  task automatic accept_vec(input logic [15:0] vec, output bit ok, output int acc_cyc);
    ok = 1'b0;
    acc_cyc = 0;
    mac_data_i  = vec;
    mac_valid_i = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (mac_ready_o) begin
        acc_cyc = cyc_cnt;
        ok = 1'b1;
        break;
      end
      step();
    end
    step();
    mac_valid_i = 1'b0;
  endtask

  // seq holds one 4-bit ADC code per plane, first plane in the top nibble.
  task automatic run_tile(input int n, input logic [15:0] seq0, input logic [15:0] seq1,
                          output bit ok, output logic [3:0] row0);
    ok = 1'b1;
    row0 = '0;
    for (int p = 0; p < n; p++) begin
      int w;
      w = 0;
      while (!plane_valid_o && w < 50) begin
        step();
        w++;
      end
      if (!plane_valid_o) begin
        ok = 1'b0;
        return;
      end
      row0[3-p] = plane_o[0];
      plane_ready_i = 1'b1;
      step();
      plane_ready_i = 1'b0;
      adc_i = {seq1[15-4*p -: 4], seq0[15-4*p -: 4]};
      adc_valid_i = 1'b1;
      step();
      adc_valid_i = 1'b0;
    end
  endtask

  task automatic wait_result(output bit ok, output int v_cyc);
    int w;
    w = 0;
    while (!valid_o && w < 100) begin
      step();
      w++;
    end
    ok = valid_o;
    v_cyc = cyc_cnt;
  endtask

  // Scenarios
  task automatic test_reset();
    checks++; if ({valid_o, mac_ready_o, busy_o, plane_valid_o} !== 4'b0000)
      $display("FAIL reset_flags: got %b expected 0000", {valid_o, mac_ready_o, busy_o, plane_valid_o});
    else passed++;
    checks++; if ({mac_data_o, plane_o} !== 20'h0)
      $display("FAIL reset_data: got %h expected 00000", {mac_data_o, plane_o});
    else passed++;
    checks++; if (dbg_state !== qracc_pkg::IDLE)
      $display("FAIL reset_state: got %0d expected %0d", dbg_state, qracc_pkg::IDLE);
    else passed++;
    @(posedge clk); #1; nrst = 1'b1;
    step();
    checks++; if (mac_ready_o !== 1'b1)
      $display("FAIL idle_ready: got %b expected 1", mac_ready_o);
    else passed++;
  endtask

  task automatic test_unsigned();
    bit ok_a, ok_t, ok_v;
    int a_cyc, v_cyc;
    logic [3:0] row0;
    set_cfg(4, 1'b1, 1, 0);
    accept_vec(16'h0000, ok_a, a_cyc);
    run_tile(4, 16'h1111, 16'h1111, ok_t, row0);
    wait_result(ok_v, v_cyc);
    checks++; if (!(ok_a && ok_t && ok_v))
      $display("FAIL unsigned_timeout: got %b%b%b expected 111", ok_a, ok_t, ok_v);
    else passed++;
    // Counted inclusively from the accept cycle to the first valid cycle.
    checks++; if (v_cyc - a_cyc + 1 != 11)
      $display("FAIL unsigned_latency: got %0d expected 11", v_cyc - a_cyc + 1);
    else passed++;
    checks++; if (mac_data_o !== 16'h0F0F)
      $display("FAIL unsigned_result: got %h expected 0f0f", mac_data_o);
    else passed++;
    step();
  endtask

  task automatic test_signed();
    bit ok_a, ok_t, ok_v;
    int a_cyc, v_cyc;
    logic [3:0] row0;
    set_cfg(4, 1'b0, 1, 0);
    accept_vec(16'h000A, ok_a, a_cyc);
    run_tile(4, 16'h1000, 16'h1111, ok_t, row0);
    wait_result(ok_v, v_cyc);
    checks++; if (!(ok_a && ok_t && ok_v))
      $display("FAIL signed_timeout: got %b%b%b expected 111", ok_a, ok_t, ok_v);
    else passed++;
    checks++; if (row0 !== 4'b1010)
      $display("FAIL signed_planes_row0: got %b expected 1010", row0);
    else passed++;
    checks++; if (mac_data_o !== 16'hFFF8)
      $display("FAIL signed_result: got %h expected fff8", mac_data_o);
    else passed++;
    step();
  endtask

  task automatic test_tiles();
    bit ok_a, ok_b, ok_t, ok_u, ok_v;
    int a_cyc, v_cyc;
    logic [3:0] row0;
    set_cfg(2, 1'b1, 2, 0);
    accept_vec(16'h0000, ok_a, a_cyc);
    run_tile(2, 16'h3300, 16'h3300, ok_t, row0);
    checks++; if (mac_ready_o !== 1'b0)
      $display("FAIL tiles_done_ready: got %b expected 0", mac_ready_o);
    else passed++;
    step();
    checks++; if ({mac_ready_o, busy_o} !== 2'b11)
      $display("FAIL tiles_load_ready: got %b expected 11", {mac_ready_o, busy_o});
    else passed++;
    accept_vec(16'h0000, ok_b, a_cyc);
    run_tile(2, 16'h3300, 16'h3300, ok_u, row0);
    wait_result(ok_v, v_cyc);
    checks++; if (!(ok_a && ok_b && ok_t && ok_u && ok_v))
      $display("FAIL tiles_timeout: got %b%b%b%b%b expected 11111", ok_a, ok_b, ok_t, ok_u, ok_v);
    else passed++;
    checks++; if (mac_data_o !== 16'h1212)
      $display("FAIL tiles_result: got %h expected 1212", mac_data_o);
    else passed++;
    step();
  endtask

  task automatic test_saturation();
    bit ok_all, ok_a, ok_t, ok_v;
    int a_cyc, v_cyc;
    logic [3:0] row0;
    ok_all = 1'b1;
    set_cfg(4, 1'b1, 4, 0);
    for (int t = 0; t < 4; t++) begin
      accept_vec(16'hFFFF, ok_a, a_cyc);
      run_tile(4, 16'h7777, 16'h8888, ok_t, row0);
      ok_all = ok_all && ok_a && ok_t;
    end
    wait_result(ok_v, v_cyc);
    checks++; if (!(ok_all && ok_v))
      $display("FAIL sat_timeout: got %b%b expected 11", ok_all, ok_v);
    else passed++;
    checks++; if (mac_data_o !== 16'h807F)
      $display("FAIL sat_result: got %h expected 807f", mac_data_o);
    else passed++;
    step();
    set_cfg(4, 1'b1, 1, 2);
    accept_vec(16'h0000, ok_a, a_cyc);
    run_tile(4, 16'h1111, 16'hFFFF, ok_t, row0);
    wait_result(ok_v, v_cyc);
    checks++; if (!(ok_a && ok_t && ok_v))
      $display("FAIL shift_timeout: got %b%b%b expected 111", ok_a, ok_t, ok_v);
    else passed++;
    checks++; if (mac_data_o !== 16'hFC03)
      $display("FAIL shift_result: got %h expected fc03", mac_data_o);
    else passed++;
    step();
  endtask

  task automatic test_clamp();
    bit ok_a, ok_t, ok_v;
    int a_cyc, v_cyc;
    logic [3:0] row0;
    set_cfg(0, 1'b1, 0, 0);
    accept_vec(16'h0000, ok_a, a_cyc);
    run_tile(1, 16'h5000, 16'hD000, ok_t, row0);
    wait_result(ok_v, v_cyc);
    checks++; if (!(ok_a && ok_t && ok_v))
      $display("FAIL clamp_timeout: got %b%b%b expected 111", ok_a, ok_t, ok_v);
    else passed++;
    checks++; if (mac_data_o !== 16'hFD05)
      $display("FAIL clamp_result: got %h expected fd05", mac_data_o);
    else passed++;
    step();
  endtask

  task automatic test_back_to_back();
    bit ok_a, ok_t, ok_v;
    int a_cyc, v_cyc, bad;
    logic [3:0] row0;
    set_cfg(7, 1'b1, 1, 0);
    ready_i = 1'b0;
    accept_vec(16'h0000, ok_a, a_cyc);
    run_tile(4, 16'h1111, 16'h1111, ok_t, row0);
    wait_result(ok_v, v_cyc);
    checks++; if (!(ok_a && ok_t && ok_v))
      $display("FAIL bp_timeout: got %b%b%b expected 111", ok_a, ok_t, ok_v);
    else passed++;
    checks++; if (mac_data_o !== 16'h0F0F)
      $display("FAIL bp_clamped_result: got %h expected 0f0f", mac_data_o);
    else passed++;
    set_cfg(4, 1'b1, 1, 0);
    mac_data_i  = 16'h0000;
    mac_valid_i = 1'b1;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if ({valid_o, mac_ready_o, mac_data_o} !== {2'b10, 16'h0F0F}) bad++;
    end
    checks++; if (bad != 0)
      $display("FAIL bp_hold: got %0d unstable cycles expected 0", bad);
    else passed++;
    ready_i = 1'b1;
    step();
    checks++; if ({valid_o, mac_ready_o} !== 2'b01)
      $display("FAIL bp_release: got %b expected 01", {valid_o, mac_ready_o});
    else passed++;
    step();
    mac_valid_i = 1'b0;
    checks++; if ({busy_o, plane_valid_o} !== 2'b11)
      $display("FAIL bp_next_accept: got %b expected 11", {busy_o, plane_valid_o});
    else passed++;
    run_tile(4, 16'h2222, 16'h2222, ok_t, row0);
    wait_result(ok_v, v_cyc);
    checks++; if (mac_data_o !== 16'h1E1E || !ok_t || !ok_v)
      $display("FAIL bp_next_result: got %h expected 1e1e", mac_data_o);
    else passed++;
    step();
  endtask

  task automatic test_reset_mid();
    bit ok_a, ok_t, ok_v;
    int a_cyc, v_cyc, bad;
    logic [3:0] row0;
    set_cfg(4, 1'b1, 1, 0);
    accept_vec(16'h0000, ok_a, a_cyc);
    plane_ready_i = 1'b1;
    step();
    plane_ready_i = 1'b0;
    checks++; if (dbg_state !== qracc_pkg::WAIT_ADC || !ok_a)
      $display("FAIL mid_state: got %0d expected %0d", dbg_state, qracc_pkg::WAIT_ADC);
    else passed++;
    #2 nrst = 1'b0;
    #1;
    checks++; if ({valid_o, mac_ready_o, busy_o, plane_valid_o, mac_data_o, plane_o} !== 24'h0)
      $display("FAIL mid_reset_outputs: got %h expected 000000",
               {valid_o, mac_ready_o, busy_o, plane_valid_o, mac_data_o, plane_o});
    else passed++;
    @(posedge clk); #1; nrst = 1'b1;
    adc_valid_i = 1'b1;
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if ({busy_o, valid_o} !== 2'b00) bad++;
    end
    adc_valid_i = 1'b0;
    checks++; if (bad != 0)
      $display("FAIL stray_adc: got %0d busy cycles expected 0", bad);
    else passed++;
    accept_vec(16'h0000, ok_a, a_cyc);
    run_tile(4, 16'h1111, 16'h1111, ok_t, row0);
    wait_result(ok_v, v_cyc);
    checks++; if (mac_data_o !== 16'h0F0F || !ok_a || !ok_t || !ok_v)
      $display("FAIL after_reset_result: got %h expected 0f0f", mac_data_o);
    else passed++;
    step();
  endtask

  initial begin
    nrst = 1'b0;
    set_cfg(4, 1'b1, 1, 0);
    mac_data_i = '0;
    mac_valid_i = 1'b0;
    plane_ready_i = 1'b0;
    adc_i = '0;
    adc_valid_i = 1'b0;
    ready_i = 1'b1;
    #12;
    test_reset();
    test_unsigned();
    test_signed();
    test_tiles();
    test_saturation();
    test_clamp();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
